xnor_gate_4bit: RTL and testbench
=================================

Name: xnor_gate_4bit

Overview:
Registered bitwise XNOR unit for the integer ALU logic-operation slice. It samples two WIDTH-bit operands on a clock edge and presents the registered XNOR result one cycle later. It also provides a valid flag and an equality flag (all result bits set). The ALU result mux selects it for the XNOR opcode.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 1..64).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_valid  input  1  operands on x/y are valid this cycle
x  input  WIDTH  operand A
y  input  WIDTH  operand B
o  output  WIDTH  registered result, o = ~(x ^ y) bitwise
out_valid  output  1  o/eq hold a result captured on the previous edge
eq  output  1  registered flag, 1 when the captured x equals the captured y (o all ones)

Behaviour:
- Single clock domain, fully synchronous. No combinational path from any input to any output.
- Reset: on a rising clk edge with rst_n=0, set o=0, eq=0 and out_valid=0. Reset has priority over in_valid.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - o <= ~(x ^ y), computed per bit: o[i]=1 iff x[i]==y[i].
  - eq <= &(~(x ^ y)).
  - out_valid <= 1.
- Idle: on a rising edge with rst_n=1 and in_valid=0, set out_valid <= 0. o and eq hold their last values and are not cleared.
- Latency: exactly 1 cycle from a sampled in_valid to out_valid/o/eq. Throughput is one operation per cycle. Back-to-back in_valid cycles produce back-to-back results with no bubbles.
- No backpressure. The downstream stage must consume the result in the cycle out_valid=1.
- Width rules:
  - Purely bitwise. No carry and no sign interpretation.
  - Bit i of o depends only on bit i of x and bit i of y.
  - eq is the AND-reduction of all WIDTH result bits.
- Boundary cases:
  - x==y gives o all ones and eq=1.
  - x==~y gives o all zeros and eq=0.
  - x=y=0 gives all ones, since XNOR of 0 and 0 is 1.
- Reset mid-stream: if rst_n is low in the same cycle as in_valid, the operation is dropped. The next cycle shows out_valid=0 and o=0.
- X/Z inputs with in_valid=0 must not disturb o or eq.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, x=4'b1111, y=4'b1111 -> o=4'b0000, eq=0, out_valid=0 after each edge.
- Complement operands: rst_n=1, in_valid=1, x=4'b1111, y=4'b0000 -> next edge o=4'b0000, eq=0, out_valid=1. Then x=4'b0000, y=4'b1111 -> o=4'b0000, eq=0.
- Mixed bits: x=4'b1111, y=4'b0110 -> next edge o=4'b0110, eq=0, out_valid=1.
- Equality: x=4'b0000, y=4'b0000 -> o=4'b1111, eq=1. Then x=4'b1010, y=4'b1010 -> o=4'b1111, eq=1.
- Hold/idle: after the x=y=4'b1010 result, drive in_valid=0 with x=4'b0101, y=4'b0000 -> out_valid=0, o stays 4'b1111, eq stays 1.
- Back-to-back and mid-stream reset:
  - Three consecutive valid pairs (1100/1010, 0011/0011, 1001/0110) -> o = 1001, 1111, 0000 on successive edges; eq = 0, 1, 0.
  - Assert rst_n=0 with in_valid=1 -> o=0000, out_valid=0 on the next edge.

Source files
------------

// File: rtl/xnor_gate_4bit.sv
// Registered bitwise XNOR unit for the ALU logic-operation slice.
// Operands are captured on a rising edge. One cycle later the unit shows
// the XNOR result, an equality flag (all result bits set) and a valid flag.
// No input reaches any output without passing through a register.
module xnor_gate_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    output logic             eq
);

    // Per-bit XNOR: bit i is set exactly when x[i] and y[i] agree.
    // There is no carry and no sign interpretation.
    function automatic logic [WIDTH-1:0] bit_xnor(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return ~(a ^ b);
    endfunction

    // The equality flag is the AND of every result bit, so it is set
    // only when the two operands match in all WIDTH positions.
    function automatic logic all_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    logic [WIDTH-1:0] xnor_p0;
    logic             eq_p0;

    logic [WIDTH-1:0] o_p1;
    logic             eq_p1;
    logic             vld_p1;

    // Stage p0: combinational result and flag from the current operands
    always_comb begin
        xnor_p0 = bit_xnor(x, y);
        eq_p0   = all_ones(xnor_p0);
    end

    // Stage p0 -> p1: capture on valid, hold on idle. Reset overrides a
    // valid operation in the same cycle, so that operation is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_p1   <= '0;
            eq_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            // In an idle cycle o and eq keep their last values.
            // Unknown operand values therefore cannot reach them.
            if (in_valid) begin
                o_p1  <= xnor_p0;
                eq_p1 <= eq_p0;
            end
        end
    end

    assign o         = o_p1;
    assign eq        = eq_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_xnor_gate_4bit.sv
// Directed bench for xnor_gate_4bit. It drives a table of
// {reset, valid, operands, expected outputs}, one row per clock edge.
// Hand-written sequences then cover idle cycles with unknown operands
// and a reset that lands in the middle of a stream.
module tb_xnor_gate_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] o;
    logic       out_valid;
    logic       eq;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] exp_o;
        logic       exp_eq;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[13];

    xnor_gate_4bit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .y        (y),
        .o        (o),
        .out_valid(out_valid),
        .eq       (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] eo,
                                input logic ee, input logic ev);
        vec_t t;
        t.rst_n  = r;
        t.vld    = v;
        t.x      = a;
        t.y      = b;
        t.exp_o  = eo;
        t.exp_eq = ee;
        t.exp_ov = ev;
        return t;
    endfunction

    // Drive one row away from the active edge, then sample just after it.
    task automatic step(input string name, input logic r, input logic v,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eo, input logic ee, input logic ev);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        x        = a;
        y        = b;
        @(posedge clk);
        #1;
        n_vec++;
        if (o !== eo) begin
            n_bad++;
            $display("FAIL %s o: got %b expected %b", name, o, eo);
        end
        n_vec++;
        if (eq !== ee) begin
            n_bad++;
            $display("FAIL %s eq: got %b expected %b", name, eq, ee);
        end
        n_vec++;
        if (out_valid !== ev) begin
            n_bad++;
            $display("FAIL %s out_valid: got %b expected %b", name, out_valid, ev);
        end
    endtask

    initial begin
        logic [3:0] xval;
        logic [3:0] zval;

        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 4'b0000;
        y        = 4'b0000;

        //              rst   vld   x        y        exp_o    eq    ov
        tbl[0]  = mk(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tbl[3]  = mk(1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 1'b1, 4'b1111, 4'b0110, 4'b0110, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1111, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 1'b0, 4'b0101, 4'b0000, 4'b1111, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 4'b1100, 4'b1010, 4'b1001, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b1111, 1'b1, 1'b1);
        tbl[10] = mk(1'b1, 1'b1, 4'b1001, 4'b0110, 4'b0000, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            step($sformatf("row%0d", i), tbl[i].rst_n, tbl[i].vld, tbl[i].x,
                 tbl[i].y, tbl[i].exp_o, tbl[i].exp_eq, tbl[i].exp_ov);
        end

        // Idle cycles with unknown operands must leave the result alone.
        xval = 4'bxxxx;
        zval = 4'bzzzz;
        step("eq_load",  1'b1, 1'b1, 4'b0110, 4'b0110, 4'b1111, 1'b1, 1'b1);
        step("idle_xz1", 1'b1, 1'b0, xval,    zval,    4'b1111, 1'b1, 1'b0);
        step("idle_xz2", 1'b1, 1'b0, zval,    xval,    4'b1111, 1'b1, 1'b0);

        // A single differing bit clears eq. Back-to-back results follow.
        step("one_bit",  1'b1, 1'b1, 4'b0101, 4'b0100, 4'b1110, 1'b0, 1'b1);
        step("msb_diff", 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0111, 1'b0, 1'b1);

        // A reset in the middle of a stream drops that operation.
        step("mid_rst",  1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        step("post_rst", 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
